// File: rtl/tc_therm_pkg.sv
// Purpose: shared types and helpers for the two's-complement -> serial thermometer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tc_therm_pkg;

    // Frame controller states: waiting for a word, or shifting out its frame.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of thermometer beats per frame for a W-bit two's-complement word.
    function automatic int unsigned frame_len(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/tc_magnitude.sv
// Purpose: combinational W-bit two's-complement to W-bit unsigned absolute value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: in_val (W, signed word), abs_val (W, unsigned magnitude).
module tc_magnitude #(
    parameter int W = 5
) (
    input  logic [W-1:0] in_val,
    output logic [W-1:0] abs_val
);

    // The result is W bits wide so the most negative input yields 2**(W-1)
    // exactly instead of overflowing back to a negative pattern.
    always_comb begin
        if (in_val[W-1]) begin
            abs_val = (~in_val) + W'(1);
        end else begin
            abs_val = in_val;
        end
    end

endmodule

// File: rtl/twos_comp_to_serial_thermometer.sv
// Purpose: accept one two's-complement word, emit sign plus a unary magnitude frame, one bit per beat.
// Latency: word taken at edge N -> bit 0 valid in cycle N+1; frame is 2**(W-1) accepted beats.
// Backpressure: out_ready low holds every output; in_ready high only while idle.
// Ports: clk, rst_n; in_valid/in_ready/in_data[W] input handshake;
//        out_valid/out_ready with out_bit, out_sign, out_last per beat.
module twos_comp_to_serial_thermometer
    import tc_therm_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_sign,
    output logic         out_last
);

    localparam int unsigned FRAME = frame_len(W);
    localparam int CW = W - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

    state_t         state_q, state_d;
    logic           sign_q,  sign_d;
    logic [W-1:0]   mag_q,   mag_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [W-1:0]   abs_w;
    logic           at_last;

    tc_magnitude #(.W(W)) u_mag (
        .in_val  (in_data),
        .abs_val (abs_w)
    );

    assign at_last = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture and beat-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)             state_d = SEND;
            SEND:    if (out_ready && at_last) state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath next values. The counter wraps to zero on the last beat, so it
    // is already cleared when the controller returns to idle.
    always_comb begin
        sign_d = sign_q;
        mag_d  = mag_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                sign_d = in_data[W-1];
                mag_d  = abs_w;
                cnt_d  = '0;
            end
        end else if (out_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Outputs depend only on registered state, never on the current inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        out_sign  = sign_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                // Magnitude may equal FRAME, which the counter cannot reach,
                // so a full-scale negative word lights every beat.
                out_bit   = ({1'b0, cnt_q} < mag_q);
                out_last  = at_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_twos_comp_to_serial_thermometer.sv
// Purpose: self-checking bench for twos_comp_to_serial_thermometer against an arithmetic frame model.
// Latency: n/a.
// Backpressure: drives random and directed out_ready stalls.
module tb_twos_comp_to_serial_thermometer;

    localparam int W     = 5;
    localparam int FRAME = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_sign;
    logic         out_last;

    int total = 0;
    int bad   = 0;

    twos_comp_to_serial_thermometer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_sign  (out_sign),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word while idle; returns once the capture edge has passed.
    task automatic offer(input int v);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = W'(v);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    // Run one full frame of value v and compare every presented beat with the model.
    // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 3-cycle stall at beat stall_at.
    // abort_at >= 0: stop once that many beats were accepted (caller resets).
    task automatic run_frame(input int v, input int mode, input int stall_at, input int abort_at);
        int exp_mag, beat, ones, cycles, stall_left;
        bit exp_sign;
        exp_mag    = (v < 0) ? -v : v;
        exp_sign   = (v < 0);
        beat       = 0;
        ones       = 0;
        cycles     = 0;
        stall_left = 3;
        offer(v);
        while (beat < FRAME && cycles < 400) begin
            if (abort_at >= 0 && beat == abort_at) return;
            check("send_valid", int'(out_valid), 1);
            check("send_in_ready", int'(in_ready), 0);
            check("bit", int'(out_bit), (beat < exp_mag) ? 1 : 0);
            check("last", int'(out_last), (beat == FRAME - 1) ? 1 : 0);
            check("sign", int'(out_sign), int'(exp_sign));
            // Input side is driven with junk during the frame; it must be ignored.
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && beat == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready && out_bit === 1'b1) ones++;
            tick();
            if (out_ready) beat++;
            cycles++;
            in_valid = 1'b0;
        end
        check("frame_done", beat, FRAME);
        check("popcount", ones, exp_mag);
        check("post_in_ready", int'(in_ready), 1);
        check("post_out_valid", int'(out_valid), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_out_sign", int'(out_sign), 0);
        check("rst_out_last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // in_valid pulses that are withdrawn before an edge do nothing
        in_valid = 1'b1;
        #2;
        in_valid = 1'b0;
        tick();
        check("glitch_idle", int'(out_valid), 0);

        // Directed values
        run_frame(5, 0, 0, -1);
        run_frame(-16, 0, 0, -1);
        run_frame(0, 0, 0, -1);
        run_frame(-1, 0, 0, -1);
        run_frame(15, 0, 0, -1);

        // Stall of three cycles at beat 4
        run_frame(7, 2, 4, -1);

        // Reset in the middle of a frame
        run_frame(10, 0, 0, 8);
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_bit", int'(out_bit), 0);
        check("mid_rst_out_sign", int'(out_sign), 0);
        check("mid_rst_out_last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(3, 0, 0, -1);

        // Sweep every input value back to back
        for (int v = -16; v < 16; v++) begin
            run_frame(v, 0, 0, -1);
        end

        // Random words with random backpressure
        for (int k = 0; k < 24; k++) begin
            run_frame($urandom_range(0, 31) - 16, 1, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
